// File: rtl/phy_types_pkg.sv
// Shared PHY transmit types: encoder symbol selects, arbiter FSM states and
// the mapping from control channel index to its comma symbol.
package phy_types_pkg;

  // Symbol select presented to the 8b/10b encoder comma/data mux.
  typedef enum logic [3:0] {
    START_PACKET_SEL   = 4'd0,
    END_PACKET_SEL     = 4'd1,
    DATA_SEL           = 4'd2,
    NACK_SEL           = 4'd3,
    ACK_SEL            = 4'd4,
    RESEND_PACKET0_SEL = 4'd5,
    RESEND_PACKET1_SEL = 4'd6,
    RESEND_PACKET2_SEL = 4'd7,
    RESEND_PACKET3_SEL = 4'd8
  } comma_sel_t;

  // Transmit arbiter sequencing states.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND_COMMA = 3'd1,
    SEND_START = 3'd2,
    SEND_DATA  = 3'd3,
    SEND_END   = 3'd4
  } arb_state_t;

  localparam int MAX_CTRL_CH = 6;
  // Channel index width sized for the largest legal channel count.
  localparam int CH_IDX_W    = 3;

  // Control channel i transmits CTRL_SEL_MAP[i]; lower index = higher priority.
  localparam comma_sel_t CTRL_SEL_MAP [MAX_CTRL_CH] = '{
    NACK_SEL, ACK_SEL,
    RESEND_PACKET0_SEL, RESEND_PACKET1_SEL,
    RESEND_PACKET2_SEL, RESEND_PACKET3_SEL
  };

endpackage

// File: rtl/arb_hdr_fifo.sv
// Per-channel control header FIFO. Push into a full FIFO is dropped unless a
// pop happens in the same cycle, in which case the push is accepted and the
// FIFO stays full. Pop of an empty FIFO is ignored.
module arb_hdr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Header storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tx_comma_arbiter.sv
// PHY transmit arbiter: queues control commas per channel, counts pending data
// packets and sequences the chosen symbols into the 8b/10b encoder.
// Build option: TX_ARB_CTRL_RR_EN selects round-robin among control channels;
// without it the lowest channel index wins.
//
// Encoder handshake: start is a one-cycle pulse that loads comma_sel and
// comma_header_out into the encoder; the encoder raises done for the cycle in
// which it finishes that symbol. done is only meaningful while busy, and
// packet_done is only looked at in a cycle where done is high.
module tx_comma_arbiter
  import phy_types_pkg::*;
#(
  parameter int NUM_CTRL   = 6,
  parameter int CTRL_DEPTH = 4,
  parameter int HDR_W      = 32,
  parameter int DATA_CNT_W = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_CTRL-1:0] ctrl_write,
  input  logic [HDR_W-1:0]    ctrl_header,
  output logic [NUM_CTRL-1:0] ctrl_full,
  input  logic                data_write,
  output logic                data_full,
  input  logic                done,
  input  logic                packet_done,
  output logic                start,
  output logic                get_data,
  output comma_sel_t          comma_sel,
  output logic [HDR_W-1:0]    comma_header_out,
  output logic                busy,
  output arb_state_t          dbg_state
);

  if (NUM_CTRL < 1 || NUM_CTRL > MAX_CTRL_CH) begin : g_bad_num_ctrl
    $error("tx_comma_arbiter: NUM_CTRL must be between 1 and MAX_CTRL_CH");
  end
  if (CTRL_DEPTH < 2 || (CTRL_DEPTH & (CTRL_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("tx_comma_arbiter: CTRL_DEPTH must be a power of two >= 2");
  end

  arb_state_t            state;
  arb_state_t            state_next;
  logic                  tok;
  logic [DATA_CNT_W-1:0] data_cnt;
  logic                  data_inc;
  logic                  grant_ctrl;
  logic                  grant_data;
  logic                  ctrl_pend;
  logic                  data_pend;
  logic [NUM_CTRL-1:0]   fifo_empty;
  logic [NUM_CTRL-1:0]   fifo_full;
  logic [NUM_CTRL-1:0]   fifo_pop;
  logic [HDR_W-1:0]      fifo_head [NUM_CTRL];
  logic [CH_IDX_W-1:0]   win_idx;
  comma_sel_t            win_sel;
  logic [HDR_W-1:0]      win_head;

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_fifo
    arb_hdr_fifo #(
      .DEPTH (CTRL_DEPTH),
      .WIDTH (HDR_W)
    ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (ctrl_write[g]),
      .pop   (fifo_pop[g]),
      .din   (ctrl_header),
      .head  (fifo_head[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g])
    );
  end

  assign ctrl_full = fifo_full;
  assign data_full = &data_cnt;
  assign ctrl_pend = !(&fifo_empty);
  assign data_pend = (data_cnt != '0);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

`ifdef TX_ARB_CTRL_RR_EN
  logic [CH_IDX_W-1:0] rr_ptr;

  // Remember the last granted control channel for the round-robin search.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rr_ptr <= '0;
    else if (grant_ctrl) rr_ptr <= win_idx;
  end

  // Round-robin pick: lowest non-empty channel above rr_ptr, else wrap to lowest.
  always_comb begin
    logic                found_hi;
    logic [CH_IDX_W-1:0] hi_idx;
    logic [CH_IDX_W-1:0] lo_idx;
    found_hi = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_CTRL - 1; i >= 0; i--) begin
      if (!fifo_empty[i]) begin
        lo_idx = CH_IDX_W'(i);
        if (i > int'(rr_ptr)) begin
          hi_idx   = CH_IDX_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    win_idx = found_hi ? hi_idx : lo_idx;
  end
`else
  // Fixed priority pick: lowest non-empty channel index wins.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_CTRL - 1; i >= 0; i--) begin
      if (!fifo_empty[i]) win_idx = CH_IDX_W'(i);
    end
  end
`endif

  // Steer the winning channel's symbol/header and pop it only on a control grant.
  always_comb begin
    win_sel  = START_PACKET_SEL;
    win_head = '0;
    fifo_pop = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (CH_IDX_W'(i) == win_idx) begin
        win_sel     = CTRL_SEL_MAP[i];
        win_head    = fifo_head[i];
        fifo_pop[i] = grant_ctrl;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state, grant decision and encoder outputs.
  always_comb begin
    state_next       = state;
    start            = 1'b0;
    get_data         = 1'b0;
    comma_sel        = START_PACKET_SEL;
    comma_header_out = '0;
    grant_ctrl       = 1'b0;
    grant_data       = 1'b0;
    unique case (state)
      IDLE: begin
        if (ctrl_pend && (!tok || !data_pend)) begin
          grant_ctrl       = 1'b1;
          start            = 1'b1;
          comma_sel        = win_sel;
          comma_header_out = win_head;
          state_next       = SEND_COMMA;
        end else if (data_pend) begin
          grant_data = 1'b1;
          start      = 1'b1;
          comma_sel  = START_PACKET_SEL;
          state_next = SEND_START;
        end
      end
      SEND_COMMA: begin
        if (done) state_next = IDLE;
      end
      SEND_START: begin
        if (done) begin
          start      = 1'b1;
          get_data   = 1'b1;
          comma_sel  = DATA_SEL;
          state_next = SEND_DATA;
        end
      end
      SEND_DATA: begin
        if (done) begin
          start = 1'b1;
          if (packet_done) begin
            comma_sel  = END_PACKET_SEL;
            state_next = SEND_END;
          end else begin
            get_data  = 1'b1;
            comma_sel = DATA_SEL;
          end
        end
      end
      SEND_END: begin
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fairness token flips on every grant so the other class is favoured next.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) tok <= 1'b0;
    else if (grant_ctrl || grant_data) tok <= ~tok;
  end

  // Pending data packet counter; a write at max is kept only if a packet leaves.
  assign data_inc = data_write && (!data_full || grant_data);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) data_cnt <= '0;
    else     data_cnt <= data_cnt + DATA_CNT_W'(data_inc) - DATA_CNT_W'(grant_data);
  end

endmodule
